// File: rtl/fetch_steer_ctrl.sv
// fetch_steer_ctrl: branch prediction steering, hazard stall/flush, halt detection and mispredict counting for fetch
module fetch_steer_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] if_pc,
  input  logic       hz_stall,
  input  logic       ex_valid,
  input  logic       ex_is_branch,
  input  logic [4:0] ex_pc,
  input  logic       ex_taken,
  input  logic [4:0] ex_target,
  input  logic       ex_pred_taken,
  input  logic [4:0] ex_pred_target,
  output logic       pc_sel,
  output logic [4:0] pc_target,
  output logic       pred_taken,
  output logic       fetch_stall,
  output logic       ifid_clr,
  output logic       idex_clr,
  output logic       halted,
  output logic [7:0] mispredict_cnt
);
  typedef enum logic [1:0] {INIT, RUN, HALT} state_t;
  state_t state_q, state_d, st;
  logic [3:0] idx_q, idx_d, li, ui;
  logic [7:0] mcnt_q, mcnt_d;
  logic [15:0] valid_q, valid_d, tag_q, tag_d;
  logic [4:0] tgt_q [16];
  logic [4:0] tgt_d [16];
  logic [1:0] cnt_q [16];
  logic [1:0] cnt_d [16];
  logic br, mis, hit, upd_hit;
  assign mispredict_cnt = mcnt_q;
  always_comb begin
    st = reset ? INIT : state_q;
    li = if_pc[3:0];
    ui = ex_pc[3:0];
    br = ex_valid & ex_is_branch;
    mis = st == RUN & br & (ex_taken != ex_pred_taken | (ex_taken & ex_target != ex_pred_target));
    hit = valid_q[li] & tag_q[li] == if_pc[4];
    upd_hit = valid_q[ui] & tag_q[ui] == ex_pc[4];
    state_d = st;
    idx_d = idx_q;
    mcnt_d = mcnt_q;
    valid_d = valid_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    pc_sel = 1'b0;
    pc_target = 5'd0;
    pred_taken = 1'b0;
    fetch_stall = 1'b0;
    ifid_clr = 1'b0;
    idex_clr = 1'b0;
    halted = st == HALT;
    if (st == INIT) begin
      fetch_stall = 1'b1;
      ifid_clr = 1'b1;
      valid_d[idx_q] = 1'b0;
      cnt_d[idx_q] = 2'b01;
      idx_d = idx_q + 4'd1;
      state_d = idx_q == 4'd15 ? RUN : INIT;
    end else if (st == HALT) begin
      fetch_stall = 1'b1;
    end else begin
      if (mis) begin
        pc_sel = 1'b1;
        pc_target = ex_taken ? ex_target : ex_pc + 5'd1;
        ifid_clr = 1'b1;
        idex_clr = 1'b1;
      end else if (hz_stall) begin
        fetch_stall = 1'b1;
        idex_clr = 1'b1;
      end else if (hit & cnt_q[li][1]) begin
        pc_sel = 1'b1;
        pc_target = tgt_q[li];
        pred_taken = 1'b1;
      end
      if (mis & mcnt_q != 8'hff) mcnt_d = mcnt_q + 8'd1;
      if (br & ex_taken) begin
        valid_d[ui] = 1'b1;
        tag_d[ui] = ex_pc[4];
        tgt_d[ui] = ex_target;
        cnt_d[ui] = !upd_hit ? 2'b10 : cnt_q[ui] == 2'b11 ? 2'b11 : cnt_q[ui] + 2'd1;
        state_d = ex_target == ex_pc ? HALT : RUN;
      end else if (br & upd_hit) begin
        cnt_d[ui] = cnt_q[ui] == 2'b00 ? 2'b00 : cnt_q[ui] - 2'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idx_q <= 4'd0;
      mcnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      mcnt_q <= mcnt_d;
    end
    valid_q <= valid_d;
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    cnt_q <= cnt_d;
  end
endmodule

// File: tb/tb_fetch_steer_ctrl.sv
// tb_fetch_steer_ctrl: directed and random checks of fetch_steer_ctrl against a behavioural model
module tb_fetch_steer_ctrl;
  logic clk = 0, reset = 0, hz_stall = 0, ex_valid = 0, ex_is_branch = 0, ex_taken = 0, ex_pred_taken = 0;
  logic [4:0] if_pc = 0, ex_pc = 0, ex_target = 0, ex_pred_target = 0;
  logic pc_sel, pred_taken, fetch_stall, ifid_clr, idex_clr, halted;
  logic [4:0] pc_target;
  logic [7:0] mispredict_cnt;
  int n_pass = 0, n_tot = 0;
  bit go = 0;
  int init_left = 16, m_mcnt = 0;
  bit m_halt = 0;
  bit m_valid [16];
  int m_tag [16];
  int m_tgt [16];
  int m_ctr [16];
  always #5 clk = ~clk;
  fetch_steer_ctrl dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .hz_stall(hz_stall), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .pc_sel(pc_sel),
    .pc_target(pc_target), .pred_taken(pred_taken), .fetch_stall(fetch_stall), .ifid_clr(ifid_clr),
    .idex_clr(idex_clr), .halted(halted), .mispredict_cnt(mispredict_cnt)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic step(input bit r, input bit hz, input bit v, input bit b, input bit tk, input bit pt,
                      input int ipc, input int epc, input int tgt, input int ptgt);
    @(posedge clk);
    #1;
    reset = r;
    hz_stall = hz;
    ex_valid = v;
    ex_is_branch = b;
    ex_taken = tk;
    ex_pred_taken = pt;
    if_pc = 5'(ipc);
    ex_pc = 5'(epc);
    ex_target = 5'(tgt);
    ex_pred_target = 5'(ptgt);
    @(negedge clk);
  endtask
  task automatic idle(input int ipc);
    step(0, 0, 0, 0, 0, 0, ipc, 0, 0, 0);
  endtask
  always @(negedge clk) if (go) begin
    int li, ui, e_sel, e_tgt, e_pt, e_st, e_if, e_id, e_h;
    bit run, br, mis, h;
    li = int'(if_pc) % 16;
    ui = int'(ex_pc) % 16;
    run = !reset && init_left == 0 && !m_halt;
    br = ex_valid && ex_is_branch;
    mis = run && br && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
    e_sel = 0; e_tgt = 0; e_pt = 0; e_st = 0; e_if = 0; e_id = 0;
    e_h = (!reset && init_left == 0 && m_halt) ? 1 : 0;
    if (reset || init_left > 0) begin
      e_st = 1; e_if = 1;
    end else if (m_halt) begin
      e_st = 1;
    end else if (mis) begin
      e_sel = 1; e_if = 1; e_id = 1;
      e_tgt = ex_taken ? int'(ex_target) : (int'(ex_pc) + 1) % 32;
    end else if (hz_stall) begin
      e_st = 1; e_id = 1;
    end else if (m_valid[li] && m_tag[li] == int'(if_pc) / 16 && m_ctr[li] >= 2) begin
      e_sel = 1; e_pt = 1; e_tgt = m_tgt[li];
    end
    chk("pc_sel", int'(pc_sel), e_sel);
    chk("pc_target", int'(pc_target), e_tgt);
    chk("pred_taken", int'(pred_taken), e_pt);
    chk("fetch_stall", int'(fetch_stall), e_st);
    chk("ifid_clr", int'(ifid_clr), e_if);
    chk("idex_clr", int'(idex_clr), e_id);
    chk("halted", int'(halted), e_h);
    if (!reset) chk("mispredict_cnt", int'(mispredict_cnt), m_mcnt);
    if (reset) begin
      init_left = 16; m_halt = 0; m_mcnt = 0;
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
    end else if (init_left > 0) begin
      init_left--;
    end else if (!m_halt) begin
      if (mis && m_mcnt < 255) m_mcnt++;
      if (br) begin
        h = m_valid[ui] && m_tag[ui] == int'(ex_pc) / 16;
        if (ex_taken) begin
          m_ctr[ui] = h ? (m_ctr[ui] < 3 ? m_ctr[ui] + 1 : 3) : 2;
          m_valid[ui] = 1; m_tag[ui] = int'(ex_pc) / 16; m_tgt[ui] = int'(ex_target);
          if (ex_target == ex_pc) m_halt = 1;
        end else if (h && m_ctr[ui] > 0) m_ctr[ui]--;
      end
    end
  end
  initial begin
    int tk, tg, ep, ip;
    go = 1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", int'(fetch_stall), 1);
    chk("rst_halted", int'(halted), 0);
    for (int i = 0; i < 16; i++) begin
      idle(i * 2);
      chk("init_stall", int'(fetch_stall), 1);
    end
    idle(7);
    chk("run_stall", int'(fetch_stall), 0);
    chk("run_sel", int'(pc_sel), 0);
    chk("run_mcnt", int'(mispredict_cnt), 0);
    step(0, 0, 1, 1, 1, 0, 0, 3, 10, 0);
    chk("mp_sel", int'(pc_sel), 1);
    chk("mp_tgt", int'(pc_target), 10);
    chk("mp_ifid", int'(ifid_clr), 1);
    chk("mp_idex", int'(idex_clr), 1);
    idle(0);
    chk("mp_cnt1", int'(mispredict_cnt), 1);
    step(0, 0, 1, 1, 1, 1, 0, 3, 10, 10);
    idle(3);
    chk("pred_sel", int'(pc_sel), 1);
    chk("pred_tgt", int'(pc_target), 10);
    chk("pred_pt", int'(pred_taken), 1);
    repeat (5) step(0, 0, 1, 1, 1, 1, 0, 5, 7, 7);
    step(0, 0, 1, 1, 0, 1, 0, 5, 7, 7);
    idle(5);
    chk("sat_still", int'(pc_sel), 1);
    chk("sat_tgt", int'(pc_target), 7);
    repeat (2) step(0, 0, 1, 1, 0, 1, 0, 5, 7, 7);
    idle(5);
    chk("sat_gone", int'(pc_sel), 0);
    step(0, 0, 1, 1, 1, 0, 0, 2, 9, 0);
    idle(2);
    chk("alias_own", int'(pc_target), 9);
    idle(18);
    chk("alias_sel", int'(pc_sel), 0);
    step(0, 1, 1, 1, 0, 1, 0, 31, 5, 5);
    chk("wrap_stall", int'(fetch_stall), 0);
    chk("wrap_tgt", int'(pc_target), 0);
    chk("wrap_sel", int'(pc_sel), 1);
    chk("wrap_ifid", int'(ifid_clr), 1);
    chk("wrap_idex", int'(idex_clr), 1);
    repeat (260) step(0, 0, 1, 1, 0, 1, 0, 20, 0, 0);
    idle(0);
    chk("mcnt_sat", int'(mispredict_cnt), 255);
    step(0, 0, 1, 1, 1, 0, 0, 4, 4, 0);
    chk("halt_redir", int'(pc_target), 4);
    idle(0);
    chk("halt_h", int'(halted), 1);
    chk("halt_st", int'(fetch_stall), 1);
    step(0, 1, 1, 1, 1, 0, 3, 7, 9, 0);
    chk("halt_hold", int'(halted), 1);
    chk("halt_sel", int'(pc_sel), 0);
    chk("halt_idex", int'(idex_clr), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hrst_halted", int'(halted), 0);
    chk("hrst_stall", int'(fetch_stall), 1);
    repeat (16) idle(0);
    idle(5);
    chk("stale5", int'(pc_sel), 0);
    idle(3);
    chk("stale3", int'(pc_sel), 0);
    chk("stale_mcnt", int'(mispredict_cnt), 0);
    for (int n = 0; n < 3000; n++) begin
      ep = int'($urandom_range(0, 31));
      tk = int'($urandom_range(0, 1));
      tg = int'($urandom_range(0, 31));
      if (tg == ep && $urandom_range(0, 3) != 0) tg = (tg + 1) % 32;
      ip = $urandom_range(0, 1) == 1 ? ep : int'($urandom_range(0, 31));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 7, tk[0], $urandom_range(0, 2) == 0 ? !tk[0] : tk[0],
           ip, ep, tg, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 31)) : tg);
    end
    go = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
